// File: rtl/alu_muldiv_pkg.sv
// Shared op codes, state codes and op-classification helpers for the
// iterative RV M-extension multiply/divide unit.
package alu_muldiv_pkg;

    localparam logic [2:0] MD_OP_MUL    = 3'd0;
    localparam logic [2:0] MD_OP_MULH   = 3'd1;
    localparam logic [2:0] MD_OP_MULHSU = 3'd2;
    localparam logic [2:0] MD_OP_MULHU  = 3'd3;
    localparam logic [2:0] MD_OP_DIV    = 3'd4;
    localparam logic [2:0] MD_OP_DIVU   = 3'd5;
    localparam logic [2:0] MD_OP_REM    = 3'd6;
    localparam logic [2:0] MD_OP_REMU   = 3'd7;

    localparam logic [1:0] MD_ST_IDLE = 2'd0;
    localparam logic [1:0] MD_ST_CALC = 2'd1;
    localparam logic [1:0] MD_ST_FIX  = 2'd2;
    localparam logic [1:0] MD_ST_DONE = 2'd3;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_left_signed(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_REM);
    endfunction

    function automatic logic op_right_signed(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per enabled cycle, sign fix-up at the end.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clk_en_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_left_i,
    input  logic [XLEN-1:0] req_right_i,
    input  logic            kill_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_result_o,
    output logic            busy_o
);

    logic [1:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            sign_l_q, sign_l_d, sign_r_q, sign_r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;

    function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic            left_neg, right_neg, div_zero, div_ovf, accept;
    logic [XLEN-1:0] left_mag, right_mag, special_res;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            div_ge;
    logic [2*XLEN-1:0] prod_fix;

    assign req_ready_o  = (state_q == MD_ST_IDLE) & ~kill_i;
    assign rsp_valid_o  = (state_q == MD_ST_DONE);
    assign busy_o       = (state_q != MD_ST_IDLE);
    assign rsp_result_o = result_q;
    assign accept       = req_valid_i & req_ready_o;

    assign left_neg  = op_left_signed(req_op_i)  & req_left_i[XLEN-1];
    assign right_neg = op_right_signed(req_op_i) & req_right_i[XLEN-1];
    assign left_mag  = negate_if(req_left_i, left_neg);
    assign right_mag = negate_if(req_right_i, right_neg);

    assign div_zero = op_is_div(req_op_i) & (req_right_i == '0);
    assign div_ovf  = ((req_op_i == MD_OP_DIV) || (req_op_i == MD_OP_REM)) &
                      (req_left_i == {1'b1, {(XLEN-1){1'b0}}}) & (req_right_i == '1);
    // op[1] separates the REM pair from the DIV pair
    assign special_res = div_zero ? (req_op_i[1] ? req_left_i : '1)
                                  : (req_op_i[1] ? '0 : req_left_i);

    // Multiply: {hi,lo} shifts right, lo holds the unconsumed multiplier bits
    assign mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
    // Divide: {hi,lo} shifts left, hi is the partial remainder, lo fills with quotient bits
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[XLEN];
    assign prod_fix  = (sign_l_q ^ sign_r_q) ? -{hi_q, lo_q} : {hi_q, lo_q};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_l_d = sign_l_q;
        sign_r_d = sign_r_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        case (state_q)
            MD_ST_IDLE: begin
                if (accept) begin
                    op_d     = req_op_i;
                    sign_l_d = left_neg;
                    sign_r_d = right_neg;
                    cnt_d    = CNT_W'(XLEN);
                    hi_d     = '0;
                    lo_d     = op_is_div(req_op_i) ? left_mag : right_mag;
                    opnd_d   = op_is_div(req_op_i) ? right_mag : left_mag;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = MD_ST_DONE;
                    end else begin
                        state_d  = MD_ST_CALC;
                    end
                end
            end
            MD_ST_CALC: begin
                if (kill_i) begin
                    state_d = MD_ST_IDLE;
                end else begin
                    if (op_is_div(op_q)) begin
                        hi_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = MD_ST_FIX;
                    end
                end
            end
            MD_ST_FIX: begin
                if (kill_i) begin
                    state_d = MD_ST_IDLE;
                end else begin
                    if (!op_is_div(op_q)) begin
                        result_d = (op_q == MD_OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                    end else if (op_q[1]) begin
                        result_d = negate_if(hi_q, sign_l_q);
                    end else begin
                        result_d = negate_if(lo_q, sign_l_q ^ sign_r_q);
                    end
                    state_d = MD_ST_DONE;
                end
            end
            default: begin
                if (kill_i || rsp_ready_i) begin
                    state_d = MD_ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= MD_ST_IDLE;
            op_q     <= '0;
            sign_l_q <= 1'b0;
            sign_r_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else if (clk_en_i) begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_l_q <= sign_l_d;
            sign_r_q <= sign_r_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes reference results, a
// negedge monitor pops them on every completed response handshake.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        clk_en_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_op_i = '0;
    logic [31:0] req_left_i = '0;
    logic [31:0] req_right_i = '0;
    logic        kill_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_result_o;
    logic        busy_o;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(32)) dut (
        .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_left_i(req_left_i), .req_right_i(req_right_i), .kill_i(kill_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .busy_o(busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural definitions
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] p;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: handshake is decided by inputs stable since posedge+1
    initial begin
        bit          holding = 1'b0;
        logic [31:0] prev = '0;
        forever begin
            @(negedge clk);
            if (!reset_i && rsp_valid_o) begin
                if (holding) check("result_stable", rsp_result_o, prev);
                if (clk_en_i && kill_i) begin
                    holding = 1'b0;
                end else if (clk_en_i && rsp_ready_i) begin
                    holding = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got 0x%08h, expected no response", rsp_result_o);
                    end else begin
                        check("rsp_result", rsp_result_o, exp_q.pop_front());
                    end
                end else begin
                    holding = 1'b1;
                    prev = rsp_result_o;
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall_after, input int stall_len, input int hold,
                          input int kill_at, input int reset_at);
        int n;
        int lat;
        int guard;
        bit special;
        bit ready_low_ok;
        bit saw;
        special = (op[2] && b == 0) ||
                  ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        lat = special ? 1 : 34 + stall_len;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_op_i = op; req_left_i = a; req_right_i = b;
        rsp_ready_i = (hold == 0); clk_en_i = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!req_ready_o && guard < 100) begin
            @(posedge clk); #1; @(negedge clk); guard++;
        end
        if (!req_ready_o) begin
            check("accept_timeout", 32'(req_ready_o), 32'd1);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        if (kill_at == 0 && reset_at == 0) exp_q.push_back(ref_model(op, a, b));
        #1; req_valid_i = 1'b0;
        n = 1;
        ready_low_ok = 1'b1;
        clk_en_i = !(stall_len > 0 && n >= stall_after && n < stall_after + stall_len);
        forever begin
            if (kill_at == n || reset_at == n) begin
                if (kill_at == n) kill_i = 1'b1; else reset_i = 1'b1;
                @(posedge clk); #1; kill_i = 1'b0; reset_i = 1'b0;
                @(negedge clk);
                check("abort_valid", 32'(rsp_valid_o), 32'd0);
                check("abort_busy", 32'(busy_o), 32'd0);
                if (reset_at == n) check("reset_result", rsp_result_o, 32'd0);
                else check("kill_ready", 32'(req_ready_o), 32'd1);
                saw = 1'b0;
                repeat (40) begin @(negedge clk); if (rsp_valid_o) saw = 1'b1; end
                check("abort_no_rsp", 32'(saw), 32'd0);
                return;
            end
            @(negedge clk);
            if (rsp_valid_o || n > 200) break;
            if (req_ready_o) ready_low_ok = 1'b0;
            @(posedge clk); n++; #1;
            clk_en_i = !(stall_len > 0 && n >= stall_after && n < stall_after + stall_len);
        end
        clk_en_i = 1'b1;
        check("latency", 32'(n), 32'(lat));
        check("ready_low_busy", 32'(ready_low_ok), 32'd1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1; @(negedge clk);
            check("hold_valid", 32'(rsp_valid_o), 32'd1);
            check("hold_ready", 32'(req_ready_o), 32'd0);
        end
        if (hold > 0) begin @(posedge clk); #1; rsp_ready_i = 1'b1; end
        @(posedge clk); #1;
        @(negedge clk);
        check("post_valid", 32'(rsp_valid_o), 32'd0);
        check("post_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(rsp_valid_o), 32'd0);
        check("reset_result", rsp_result_o, 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1; reset_i = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, 0, 0, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0);
        run_op(3'd5, 32'd7, 32'd2, 0, 0, 0, 0, 0);
        run_op(3'd7, 32'd7, 32'd2, 0, 0, 0, 0, 0);
        run_op(3'd4, 32'd5, 32'd0, 0, 0, 0, 0, 0);
        run_op(3'd7, 32'd5, 32'd0, 0, 0, 0, 0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        run_op(3'd0, 32'd12345, 32'd678, 10, 4, 0, 0, 0);
        run_op(3'd6, 32'hFFFF_FF00, 32'd7, 0, 0, 5, 0, 0);
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 10, 0);
        run_op(3'd5, 32'd100, 32'd7, 0, 0, 0, 0, 0);
        run_op(3'd4, 32'd1000, 32'd3, 0, 0, 0, 0, 10);
        run_op(3'd2, 32'h8000_0001, 32'h7FFF_FFFF, 0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   $urandom_range(2, 30), $urandom_range(0, 3), $urandom_range(0, 2), 0, 0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
